// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types and helpers for the I2S transmitter.
//   stereo_sample_t : left/right pair, stored sign-extended to MAX_SAMPLE_W
//   channel_e       : slot identity, also the lrck encoding (0 = left)
//   frame_cycles()  : clk cycles per full left+right frame
package i2s_pkg;
  localparam int MAX_SAMPLE_W = 32;

  typedef struct packed {
    logic signed [MAX_SAMPLE_W-1:0] left;
    logic signed [MAX_SAMPLE_W-1:0] right;
  } stereo_sample_t;

  typedef enum logic {LEFT = 1'b0, RIGHT = 1'b1} channel_e;

  function automatic int frame_cycles(input int slot_width, input int bclk_div);
    return 2 * slot_width * bclk_div;
  endfunction
endpackage

// File: rtl/i2s_frame_timer.sv
// i2s_frame_timer: bit/slot timebase for the I2S serializer.
//   clk, reset       : MCLK domain, synchronous active-high reset
//   o_bit_tick       : last clk cycle of the current bit (shift point)
//   o_slot_boundary  : last clk cycle of the current slot (load point)
//   o_next_channel   : channel of the slot that starts after the boundary
//   o_channel        : current channel (drives lrck directly)
module i2s_frame_timer import i2s_pkg::*; #(
  parameter int SLOT_WIDTH = 32,
  parameter int BCLK_DIV   = 4
) (
  input  logic     clk,
  input  logic     reset,
  output logic     o_bit_tick,
  output logic     o_slot_boundary,
  output channel_e o_next_channel,
  output channel_e o_channel
);
  localparam int PW = $clog2(BCLK_DIV);
  localparam int IW = $clog2(SLOT_WIDTH);
  localparam logic [PW-1:0] PH_LAST  = PW'(BCLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(SLOT_WIDTH - 1);

  logic [PW-1:0] r_phase;
  logic [IW-1:0] r_idx;
  channel_e      r_ch;

  assign o_bit_tick      = (r_phase == PH_LAST);
  assign o_slot_boundary = o_bit_tick && (r_idx == IDX_LAST);
  assign o_next_channel  = (r_ch == LEFT) ? RIGHT : LEFT;
  assign o_channel       = r_ch;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase <= '0;
      r_idx   <= '0;
      r_ch    <= LEFT;
    end else begin
      if (o_bit_tick) begin
        r_phase <= '0;
        r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_phase <= r_phase + 1'b1;
      end
      if (o_slot_boundary) r_ch <= o_next_channel;
    end
  end
endmodule

// File: rtl/i2s_serializer.sv
// i2s_serializer: Philips-I2S stereo transmitter with a one-deep holding
// buffer and valid/ready input.
//   clk, reset          : MCLK domain, synchronous active-high reset
//   in_left/in_right    : signed PCM pair, in_valid/in_ready handshake
//   volume, mute        : load-time attenuation, active only when the macro
//                         I2S_SERIALIZER_VOLUME_EN is defined (else ignored)
//   lrck, dac           : word select (0 = left) and MSB-first serial data
//   underrun            : 1-cycle pulse when a left-slot load had no pair
module i2s_serializer import i2s_pkg::*; #(
  parameter int SAMPLE_WIDTH     = 16,
  parameter int SLOT_WIDTH       = 32,
  parameter int BCLK_DIV         = 4,
  parameter int MONO             = 0,
  parameter int HOLD_ON_UNDERRUN = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] in_left,
  input  logic [SAMPLE_WIDTH-1:0] in_right,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              volume,
  input  logic                    mute,
  output logic                    lrck,
  output logic                    dac,
  output logic                    underrun
);
  // sample sits right after the leading I2S delay bit, zero padded below
  localparam int PAD = SLOT_WIDTH - 1 - SAMPLE_WIDTH;

  logic     w_bit_tick, w_slot_boundary;
  channel_e w_next_ch, w_ch;

  i2s_frame_timer #(.SLOT_WIDTH(SLOT_WIDTH), .BCLK_DIV(BCLK_DIV)) u_timer (
    .clk            (clk),
    .reset          (reset),
    .o_bit_tick     (w_bit_tick),
    .o_slot_boundary(w_slot_boundary),
    .o_next_channel (w_next_ch),
    .o_channel      (w_ch)
  );

  stereo_sample_t r_cur, r_pend;
  logic           r_pend_vld, r_underrun;
  logic [SLOT_WIDTH-1:0] r_shift;

  stereo_sample_t                 w_cur_nxt;
  logic signed [MAX_SAMPLE_W-1:0] w_raw, w_shr, w_adj;
  logic [SLOT_WIDTH-1:0]          w_load;
  logic                           w_accept, w_unused;

  assign in_ready = !r_pend_vld;
  assign w_accept = in_valid && in_ready;

  // Sample selection for the slot about to start. Entering left consumes
  // the pending pair directly (bypass) or falls back to hold/zero.
  always_comb begin
    w_cur_nxt = r_cur;
    w_raw     = '0;
    if (w_next_ch == RIGHT) begin
      w_raw = (MONO != 0) ? r_cur.left : r_cur.right;
    end else if (r_pend_vld) begin
      w_cur_nxt = r_pend;
      w_raw     = r_pend.left;
    end else if (HOLD_ON_UNDERRUN != 0) begin
      w_raw = r_cur.left;
    end else begin
      w_cur_nxt = '0;
    end
  end

  // kept as its own signed net so the shift stays arithmetic
  assign w_shr = w_raw >>> volume;

`ifdef I2S_SERIALIZER_VOLUME_EN
  assign w_adj    = mute ? '0 : w_shr;
  assign w_unused = ^w_adj;
`else
  assign w_adj    = w_raw;
  assign w_unused = ^{w_adj, w_shr, mute};
`endif

  assign w_load = SLOT_WIDTH'({1'b0, w_adj[SAMPLE_WIDTH-1:0]}) << PAD;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur      <= '0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_underrun <= 1'b0;
      r_shift    <= '0;
    end else begin
      r_underrun <= 1'b0;
      if (w_slot_boundary) begin
        r_shift <= w_load;
        if (w_next_ch == LEFT) begin
          r_cur <= w_cur_nxt;
          if (!r_pend_vld) r_underrun <= 1'b1;
        end
      end else if (w_bit_tick) begin
        r_shift <= {r_shift[SLOT_WIDTH-2:0], 1'b0};
      end
      // consume and accept are exclusive: accept needs the buffer empty,
      // and an empty-buffer consume leaves the new pair pending
      if (w_slot_boundary && w_next_ch == LEFT && r_pend_vld) begin
        r_pend_vld <= 1'b0;
      end else if (w_accept) begin
        r_pend.left  <= MAX_SAMPLE_W'($signed(in_left));
        r_pend.right <= MAX_SAMPLE_W'($signed(in_right));
        r_pend_vld   <= 1'b1;
      end
    end
  end

  assign lrck     = w_ch;
  assign dac      = r_shift[SLOT_WIDTH-1];
  assign underrun = r_underrun;
endmodule

// File: tb/tb_i2s_serializer.sv
// Directed bench: u0 uses default parameters, u1 is a 24-bit mono,
// BCLK_DIV=2, zero-on-underrun build. Cycle N means the value seen just
// after the Nth rising edge following reset release (edge 0 is the first).
module tb_i2s_serializer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] l0, r0;
  logic        v0, rdy0, lrck0, dac0, und0, mute0;
  logic [2:0]  vol0;
  logic [23:0] l1, r1;
  logic        v1, rdy1, lrck1, dac1, und1, mute1;
  logic [2:0]  vol1;

  i2s_serializer u0 (
    .clk(clk), .reset(reset), .in_left(l0), .in_right(r0), .in_valid(v0),
    .in_ready(rdy0), .volume(vol0), .mute(mute0), .lrck(lrck0), .dac(dac0),
    .underrun(und0));

  i2s_serializer #(.SAMPLE_WIDTH(24), .SLOT_WIDTH(32), .BCLK_DIV(2), .MONO(1),
                   .HOLD_ON_UNDERRUN(0)) u1 (
    .clk(clk), .reset(reset), .in_left(l1), .in_right(r1), .in_valid(v1),
    .in_ready(rdy1), .volume(vol1), .mute(mute1), .lrck(lrck1), .dac(dac1),
    .underrun(und1));

  // tuple order: {lrck, dac, underrun, in_ready}
  logic [3:0] t0, t1;
  assign t0 = {lrck0, dac0, und0, rdy0};
  assign t1 = {lrck1, dac1, und1, rdy1};

  int n_vec = 0;
  int n_bad = 0;
  int edge_n = -1;

  typedef struct {
    bit          rst;
    int          cyc;
    bit          push;
    logic [15:0] l, r;
    logic [3:0]  exp;
    bit          cap;
    logic [31:0] word;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit rst, int cyc, bit push, logic [15:0] l,
                              logic [15:0] r, logic [3:0] exp, bit cap,
                              logic [31:0] word);
    vec_t v;
    v.rst = rst; v.cyc = cyc; v.push = push; v.l = l; v.r = r;
    v.exp = exp; v.cap = cap; v.word = word;
    return v;
  endfunction

  function automatic logic [31:0] w16(logic [15:0] x);
    return {1'b0, x, 15'h0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic adv(input int e);
    while (edge_n < e) tick();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, edge_n);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    v0 = 1'b0; v1 = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    edge_n = -1;
  endtask

  // Sample dac at the first and last clk of each bit of one slot.
  task automatic cap(input int start, input int div, input bit sel,
                     input logic [31:0] exp, input string nm);
    logic [31:0] wa, wb;
    wa = '0; wb = '0;
    for (int k = 0; k < 32; k++) begin
      adv(start + div * k);
      wa[31-k] = sel ? dac1 : dac0;
      adv(start + div * k + div - 1);
      wb[31-k] = sel ? dac1 : dac0;
    end
    chk({nm, "_first"}, wa, exp);
    chk({nm, "_last"}, wb, exp);
  endtask

  initial begin
    l0 = '0; r0 = '0; v0 = 1'b0; vol0 = '0; mute0 = 1'b0;
    l1 = '0; r1 = '0; v1 = 1'b0; vol1 = '0; mute1 = 1'b0;

    // idle: lrck toggles every 128 cycles, underrun every frame, dac silent
    tbl.push_back(mk(1,   0, 0, 16'h0, 16'h0, 4'b0001, 0, 32'h0));
    tbl.push_back(mk(0, 126, 0, 16'h0, 16'h0, 4'b0001, 0, 32'h0));
    tbl.push_back(mk(0, 127, 0, 16'h0, 16'h0, 4'b1001, 0, 32'h0));
    tbl.push_back(mk(0, 254, 0, 16'h0, 16'h0, 4'b1001, 0, 32'h0));
    tbl.push_back(mk(0, 255, 0, 16'h0, 16'h0, 4'b0011, 0, 32'h0));
    tbl.push_back(mk(0, 256, 0, 16'h0, 16'h0, 4'b0001, 0, 32'h0));
    tbl.push_back(mk(0, 383, 0, 16'h0, 16'h0, 4'b1001, 0, 32'h0));
    tbl.push_back(mk(0, 510, 0, 16'h0, 16'h0, 4'b1001, 0, 32'h0));
    tbl.push_back(mk(0, 511, 0, 16'h0, 16'h0, 4'b0011, 0, 32'h0));
    // one pair early, then starvation repeats it
    tbl.push_back(mk(1,  10, 1, 16'hA5C3, 16'h0001, 4'b0000, 0, 32'h0));
    tbl.push_back(mk(0, 254, 0, 16'h0, 16'h0, 4'b1000, 0, 32'h0));
    tbl.push_back(mk(0, 255, 0, 16'h0, 16'h0, 4'b0001, 1, w16(16'hA5C3)));
    tbl.push_back(mk(0, 383, 0, 16'h0, 16'h0, 4'b1001, 1, w16(16'h0001)));
    tbl.push_back(mk(0, 511, 0, 16'h0, 16'h0, 4'b0011, 1, w16(16'hA5C3)));
    // push on the consume edge: underrun now, pair used a frame later;
    // second push while full is refused
    tbl.push_back(mk(1, 255, 1, 16'h1234, 16'h5678, 4'b0010, 0, 32'h0));
    tbl.push_back(mk(0, 300, 1, 16'hFFFF, 16'hFFFF, 4'b0000, 0, 32'h0));
    tbl.push_back(mk(0, 511, 0, 16'h0, 16'h0, 4'b0001, 1, w16(16'h1234)));
    tbl.push_back(mk(0, 639, 0, 16'h0, 16'h0, 4'b1001, 1, w16(16'h5678)));
    tbl.push_back(mk(0, 767, 0, 16'h0, 16'h0, 4'b0011, 1, w16(16'h1234)));

    do_reset();
    chk("reset_u0", {28'h0, t0}, {28'h0, 4'b0001});
    chk("reset_u1", {28'h0, t1}, {28'h0, 4'b0001});
    chk("frame_cycles", i2s_pkg::frame_cycles(32, 4), 256);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      adv(tbl[i].cyc - 1);
      if (tbl[i].push) begin
        v0 = 1'b1; l0 = tbl[i].l; r0 = tbl[i].r;
      end
      adv(tbl[i].cyc);
      v0 = 1'b0;
      chk($sformatf("vec%0d", i), {28'h0, t0}, {28'h0, tbl[i].exp});
      if (tbl[i].cap) cap(tbl[i].cyc, 4, 1'b0, tbl[i].word, $sformatf("vec%0d_slot", i));
    end

    // mono 24-bit build: both slots replay left; starvation gives zeros
    do_reset();
    adv(4);
    v1 = 1'b1; l1 = 24'h800001; r1 = 24'h7FFFFF;
    adv(5);
    v1 = 1'b0;
    chk("m_push", {28'h0, t1}, {28'h0, 4'b0000});
    adv(63);
    chk("m_63", {28'h0, t1}, {28'h0, 4'b1000});
    adv(127);
    chk("m_127", {28'h0, t1}, {28'h0, 4'b0001});
    cap(127, 2, 1'b1, {1'b0, 24'h800001, 7'h0}, "m_left");
    cap(191, 2, 1'b1, {1'b0, 24'h800001, 7'h0}, "m_right");
    adv(255);
    chk("m_255", {28'h0, t1}, {28'h0, 4'b0011});
    cap(255, 2, 1'b1, 32'h0, "m_zero_l");
    cap(319, 2, 1'b1, 32'h0, "m_zero_r");

    // reset in mid right slot drops the pending pair and all state
    do_reset();
    adv(9);
    v0 = 1'b1; l0 = 16'hA5C3; r0 = 16'hFFFF;
    adv(10);
    v0 = 1'b0;
    adv(299);
    v0 = 1'b1; l0 = 16'h1111; r0 = 16'h2222;
    adv(300);
    v0 = 1'b0;
    adv(399);
    chk("pre_rst", {28'h0, t0}, {28'h0, 4'b1100});
    reset = 1'b1;
    tick();
    chk("mid_rst", {28'h0, t0}, {28'h0, 4'b0001});
    reset = 1'b0;
    edge_n = -1;
    adv(255);
    chk("post_rst_und", {28'h0, t0}, {28'h0, 4'b0011});
    cap(255, 4, 1'b0, 32'h0, "post_rst_slot");

`ifdef I2S_SERIALIZER_VOLUME_EN
    // -32768 >>> 1 = C000, >>> 2 = E000; mute forces zero
    do_reset();
    vol0 = 3'd1;
    adv(9);
    v0 = 1'b1; l0 = 16'h8000; r0 = 16'h8000;
    adv(10);
    v0 = 1'b0;
    cap(255, 4, 1'b0, w16(16'hC000), "vol1");
    vol0 = 3'd2;
    cap(383, 4, 1'b0, w16(16'hE000), "vol2");
    mute0 = 1'b1;
    cap(511, 4, 1'b0, 32'h0, "mute");
    mute0 = 1'b0;
    vol0 = 3'd0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
